// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single data RAM between the sequence controller and the I/O port block.
// Optional build macro ARB_ROUND_ROBIN_EN: simultaneous requests alternate by last owner.
module ram_arbiter #(
    parameter int unsigned AW            = 7,
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned MAX_WAIT      = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          SEQ_REQ,
    input  logic          SEQ_WE,
    input  logic [AW-1:0] SEQ_ADDR,
    output logic          SEQ_GNT,
    output logic          SEQ_DONE,
    input  logic          PORT_REQ,
    input  logic          PORT_WE,
    input  logic [AW-1:0] PORT_ADDR,
    output logic          PORT_GNT,
    output logic          PORT_DONE,
    output logic [AW-1:0] RAM_ADDR,
    output logic          RAM_CS,
    output logic          RAM_OE,
    output logic          RAM_WE,
    output logic          RDR_EN,
    output logic          BUSY
);

    localparam int unsigned CW = 4;
    localparam int unsigned WW = 8;
    localparam logic [CW-1:0] CNT_LOAD = CW'(ACCESS_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_LIM = WW'(MAX_WAIT);
    localparam logic          OWN_SEQ  = 1'b0;
    localparam logic          OWN_PORT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          last_q, last_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          seq_gnt_q, seq_gnt_d;
    logic          seq_done_q, seq_done_d;
    logic          port_gnt_q, port_gnt_d;
    logic          port_done_q, port_done_d;
    logic          cs_q, cs_d;
    logic          oe_q, oe_d;
    logic          ram_we_q, ram_we_d;
    logic          rdr_en_q, rdr_en_d;
    logic          busy_q, busy_d;

    logic          any_req;
    logic          both_req;
    logic          starve;
    logic          pick_port;
    logic          we_sel;
    logic [AW-1:0] addr_sel;
    logic          grant_port;

    // Arbitration decision; only consumed while in IDLE.
    assign any_req  = SEQ_REQ | PORT_REQ;
    assign both_req = SEQ_REQ & PORT_REQ;
    assign starve   = PORT_REQ & (wait_q >= WAIT_LIM);
`ifdef ARB_ROUND_ROBIN_EN
    assign pick_port = starve | (both_req ? (last_q == OWN_SEQ) : ~SEQ_REQ);
`else
    assign pick_port = starve | ~SEQ_REQ;
`endif
    assign we_sel   = pick_port ? PORT_WE   : SEQ_WE;
    assign addr_sel = pick_port ? PORT_ADDR : SEQ_ADDR;

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wait_d      = wait_q;
        last_d      = last_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        seq_gnt_d   = 1'b0;
        seq_done_d  = 1'b0;
        port_gnt_d  = 1'b0;
        port_done_d = 1'b0;
        cs_d        = 1'b0;
        oe_d        = 1'b0;
        ram_we_d    = 1'b0;
        rdr_en_d    = 1'b0;
        busy_d      = 1'b0;
        grant_port  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d    = ST_ACCESS;
                    owner_d    = pick_port;
                    we_d       = we_sel;
                    addr_d     = addr_sel;
                    cnt_d      = CNT_LOAD;
                    grant_port = pick_port;
                    seq_gnt_d  = ~pick_port;
                    port_gnt_d = pick_port;
                    cs_d       = 1'b1;
                    oe_d       = ~we_sel;
                    ram_we_d   = we_sel;
                    rdr_en_d   = ~we_sel & (CNT_LOAD == '0);
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d     = ST_DONE;
                    seq_done_d  = (owner_q == OWN_SEQ);
                    port_done_d = (owner_q == OWN_PORT);
                end else begin
                    cnt_d      = cnt_q - CW'(1);
                    seq_gnt_d  = (owner_q == OWN_SEQ);
                    port_gnt_d = (owner_q == OWN_PORT);
                    cs_d       = 1'b1;
                    oe_d       = ~we_q;
                    ram_we_d   = we_q;
                    // The cycle about to start is the final one of the access.
                    rdr_en_d   = ~we_q & (cnt_q == CW'(1));
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                last_d  = owner_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Starvation counter: cleared on port grant, saturates otherwise.
        if (grant_port) begin
            wait_d = '0;
        end else if (PORT_REQ && !port_gnt_q && (wait_q != '1)) begin
            wait_d = wait_q + WW'(1);
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wait_q      <= '0;
            last_q      <= OWN_PORT;
            owner_q     <= OWN_SEQ;
            we_q        <= 1'b0;
            addr_q      <= '0;
            seq_gnt_q   <= 1'b0;
            seq_done_q  <= 1'b0;
            port_gnt_q  <= 1'b0;
            port_done_q <= 1'b0;
            cs_q        <= 1'b0;
            oe_q        <= 1'b0;
            ram_we_q    <= 1'b0;
            rdr_en_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wait_q      <= wait_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            seq_gnt_q   <= seq_gnt_d;
            seq_done_q  <= seq_done_d;
            port_gnt_q  <= port_gnt_d;
            port_done_q <= port_done_d;
            cs_q        <= cs_d;
            oe_q        <= oe_d;
            ram_we_q    <= ram_we_d;
            rdr_en_q    <= rdr_en_d;
            busy_q      <= busy_d;
        end
    end

    assign SEQ_GNT   = seq_gnt_q;
    assign SEQ_DONE  = seq_done_q;
    assign PORT_GNT  = port_gnt_q;
    assign PORT_DONE = port_done_q;
    assign RAM_ADDR  = addr_q;
    assign RAM_CS    = cs_q;
    assign RAM_OE    = oe_q;
    assign RAM_WE    = ram_we_q;
    assign RDR_EN    = rdr_en_q;
    assign BUSY      = busy_q;

endmodule
